mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) round-robin arbiter in front of a single shared memory port.
// Each transaction runs IDLE -> BUSY -> RESP and is bounded by a TIMEOUT-cycle ack watchdog.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [2:0]  mem_ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [7:0]  TIMEOUT_C   = 8'(TIMEOUT);
  localparam logic        GRANT_CPU   = 1'b0;
  localparam logic        GRANT_DMA   = 1'b1;
  localparam logic [2:0]  CTRL_FULL   = 3'b000;
  localparam logic [31:0] RDATA_ABORT = 32'hFFFF_FFFF;

  // Round-robin pick: a lone requester always wins; on a tie the side not served last wins.
  function automatic logic pick_dma(input logic cpu_pending,
                                    input logic dma_pending,
                                    input logic last_was_dma);
    return dma_pending && (!cpu_pending || !last_was_dma);
  endfunction

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        last_grant_r;
  logic        grant_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [2:0]  ctrl_r;
  logic        mem_en_r;
  logic        mem_we_r;
  logic        cpu_ready_r;
  logic        dma_ready_r;
  logic        err_r;
  logic [31:0] cpu_rdata_r;
  logic [31:0] dma_rdata_r;
  logic        grant_dma_s;

  // Grant decision for the request currently presented in IDLE.
  always_comb begin
    grant_dma_s = pick_dma(cpu_req, dma_req, last_grant_r);
  end

  // Transaction FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      last_grant_r <= GRANT_DMA;
      grant_r      <= GRANT_CPU;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      ctrl_r       <= 3'd0;
      mem_en_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_ready_r  <= 1'b0;
      dma_ready_r  <= 1'b0;
      err_r        <= 1'b0;
      cpu_rdata_r  <= 32'd0;
      dma_rdata_r  <= 32'd0;
    end else begin
      cpu_ready_r <= 1'b0;
      dma_ready_r <= 1'b0;
      err_r       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cpu_req || dma_req) begin
            grant_r      <= grant_dma_s;
            last_grant_r <= grant_dma_s;
            cnt_r        <= 8'd0;
            mem_en_r     <= 1'b1;
            state_r      <= BUSY;
            if (grant_dma_s) begin
              we_r     <= dma_we;
              addr_r   <= dma_addr;
              wdata_r  <= dma_wdata;
              ctrl_r   <= CTRL_FULL;
              mem_we_r <= dma_we;
            end else begin
              we_r     <= cpu_we;
              addr_r   <= cpu_addr;
              wdata_r  <= cpu_wdata;
              ctrl_r   <= cpu_ctrl;
              mem_we_r <= cpu_we;
            end
          end else begin
            state_r  <= IDLE;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
          end
        end
        BUSY: begin
          // An ack on the very cycle the counter hits TIMEOUT still wins over the abort.
          if (mem_ack) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            cpu_ready_r <= (grant_r == GRANT_CPU);
            dma_ready_r <= (grant_r == GRANT_DMA);
            state_r     <= RESP;
            if (!we_r) begin
              if (grant_r == GRANT_DMA) begin
                dma_rdata_r <= mem_rdata;
              end else begin
                cpu_rdata_r <= mem_rdata;
              end
            end else begin
              cpu_rdata_r <= cpu_rdata_r;
            end
          end else if (cnt_r == TIMEOUT_C) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            err_r       <= 1'b1;
            cpu_ready_r <= (grant_r == GRANT_CPU);
            dma_ready_r <= (grant_r == GRANT_DMA);
            state_r     <= RESP;
            if (!we_r) begin
              if (grant_r == GRANT_DMA) begin
                dma_rdata_r <= RDATA_ABORT;
              end else begin
                cpu_rdata_r <= RDATA_ABORT;
              end
            end else begin
              cpu_rdata_r <= cpu_rdata_r;
            end
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            state_r <= BUSY;
          end
        end
        RESP: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          cnt_r    <= 8'd0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign mem_ctrl  = ctrl_r;
  assign cpu_ready = cpu_ready_r;
  assign dma_ready = dma_ready_r;
  assign cpu_rdata = cpu_rdata_r;
  assign dma_rdata = dma_rdata_r;
  assign err       = err_r;
  assign state_out = state_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4), hand-computed expectations.
module tb_mem_arbiter;

  localparam logic [2:0] HALFU = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [2:0]  cpu_ctrl;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_en, mem_we, err;
  logic [2:0]  mem_ctrl;
  logic [1:0]  state_out;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ctrl(cpu_ctrl), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .state_out(state_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int seq[3];
  int n;
  int both;
  int busy;

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_ctrl = 3'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    tick; tick;
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_ready_err", 32'({cpu_ready, dma_ready, err}), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_ctrl", 32'(mem_ctrl), 32'd0);
    rst = 1'b0;

    // CPU Halfu read, ack after two BUSY cycles
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010; cpu_ctrl = HALFU;
    tick;
    check("rd_state_busy", 32'(state_out), 32'd1);
    check("rd_mem_en", 32'(mem_en), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    check("rd_mem_addr", mem_addr, 32'h0000_0010);
    check("rd_mem_ctrl", 32'(mem_ctrl), 32'(HALFU));
    tick; tick;
    check("rd_still_busy", 32'(state_out), 32'd1);
    check("rd_no_early_ready", 32'(cpu_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    tick;
    check("rd_cpu_ready", 32'(cpu_ready), 32'd1);
    check("rd_dma_ready", 32'(dma_ready), 32'd0);
    check("rd_err", 32'(err), 32'd0);
    check("rd_cpu_rdata", cpu_rdata, 32'h0000_ABCD);
    check("rd_resp_mem_en", 32'(mem_en), 32'd0);
    check("rd_resp_state", 32'(state_out), 32'd2);
    check("rd_ctrl_hold", 32'(mem_ctrl), 32'(HALFU));
    cpu_req = 1'b0; mem_ack = 1'b0;
    tick;
    check("rd_ready_pulse", 32'(cpu_ready), 32'd0);
    check("rd_back_idle", 32'(state_out), 32'd0);

    // Stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    tick; tick;
    check("stray_ack_rdata", cpu_rdata, 32'h0000_ABCD);
    check("stray_ack_state", 32'(state_out), 32'd0);
    check("stray_ack_ready", 32'({cpu_ready, dma_ready}), 32'd0);
    mem_ack = 1'b0;

    // DMA write with ack in the first BUSY cycle
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h0000_0100; dma_wdata = 32'h1234_5678;
    tick;
    check("dw_mem_en", 32'(mem_en), 32'd1);
    check("dw_mem_we", 32'(mem_we), 32'd1);
    check("dw_mem_ctrl", 32'(mem_ctrl), 32'd0);
    check("dw_mem_addr", mem_addr, 32'h0000_0100);
    check("dw_mem_wdata", mem_wdata, 32'h1234_5678);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick;
    check("dw_dma_ready", 32'(dma_ready), 32'd1);
    check("dw_cpu_ready", 32'(cpu_ready), 32'd0);
    check("dw_dma_rdata_kept", dma_rdata, 32'd0);
    dma_req = 1'b0; dma_we = 1'b0; mem_ack = 1'b0;
    tick;
    check("dw_ready_pulse", 32'(dma_ready), 32'd0);

    // Tie after reset: CPU, DMA, CPU
    rst = 1'b1;
    tick;
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0300;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    n = 0; both = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick;
      if (cpu_ready && dma_ready) both = 1;
      if (cpu_ready) begin
        seq[n] = 0; n++;
      end else if (dma_ready) begin
        seq[n] = 1; n++;
      end
    end
    check("rr_count", 32'(n), 32'd3);
    check("rr_first_cpu", 32'(seq[0]), 32'd0);
    check("rr_second_dma", 32'(seq[1]), 32'd1);
    check("rr_third_cpu", 32'(seq[2]), 32'd0);
    check("rr_never_both", 32'(both), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
    tick; tick;

    // Requester changes inputs and drops req during BUSY
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
    tick;
    check("chg_addr_latched", mem_addr, 32'h0000_0020);
    cpu_addr = 32'h0000_0040; cpu_we = 1'b1; cpu_wdata = 32'hCAFE_0000; cpu_req = 1'b0;
    tick;
    check("chg_addr_stable1", mem_addr, 32'h0000_0020);
    check("chg_we_stable", 32'(mem_we), 32'd0);
    check("chg_still_busy", 32'(state_out), 32'd1);
    tick;
    check("chg_addr_stable2", mem_addr, 32'h0000_0020);
    mem_ack = 1'b1; mem_rdata = 32'h0000_5555;
    tick;
    check("chg_ready_after_drop", 32'(cpu_ready), 32'd1);
    check("chg_rdata", cpu_rdata, 32'h0000_5555);
    check("chg_addr_resp", mem_addr, 32'h0000_0020);
    mem_ack = 1'b0; cpu_we = 1'b0;
    tick; tick;

    // Timeout abort on a CPU read
    cpu_req = 1'b1; cpu_addr = 32'h0000_0030;
    tick;
    busy = 0;
    for (int i = 0; i < 30 && state_out == 2'd1; i++) begin
      busy++;
      tick;
    end
    check("to_busy_cycles", 32'(busy), 32'd5);
    check("to_err", 32'(err), 32'd1);
    check("to_cpu_ready", 32'(cpu_ready), 32'd1);
    check("to_cpu_rdata", cpu_rdata, 32'hFFFF_FFFF);
    check("to_dma_ready", 32'(dma_ready), 32'd0);
    cpu_req = 1'b0;
    tick;
    check("to_err_pulse", 32'(err), 32'd0);
    tick;

    // Ack arriving exactly when the counter reaches TIMEOUT
    cpu_req = 1'b1; cpu_addr = 32'h0000_0034;
    tick;
    repeat (4) tick;
    check("edge_still_busy", 32'(state_out), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    tick;
    check("edge_no_err", 32'(err), 32'd0);
    check("edge_cpu_ready", 32'(cpu_ready), 32'd1);
    check("edge_cpu_rdata", cpu_rdata, 32'h0BAD_F00D);
    cpu_req = 1'b0; mem_ack = 1'b0;
    tick; tick;

    // Reset during a DMA BUSY, then CPU wins the first tie
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0400;
    tick;
    check("mid_busy", 32'(state_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_state", 32'(state_out), 32'd0);
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_dma_rdata", dma_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("mid_rst_no_pulse", 32'({cpu_ready, dma_ready, err}), 32'd0);
    end
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500;
    tick;
    check("post_rst_no_pulse", 32'({cpu_ready, dma_ready, err}), 32'd0);
    check("post_rst_cpu_grant", mem_addr, 32'h0000_0500);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0077;
    tick;
    check("post_rst_cpu_ready", 32'(cpu_ready), 32'd1);
    check("post_rst_dma_ready", 32'(dma_ready), 32'd0);
    cpu_req = 1'b0; dma_req = 1'b0; mem_ack = 1'b0;
    tick; tick;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
